// File: rtl/calc_pkg.sv
// Shared types and constants for the calc_sequencer BCD add/subtract block.
// Holds the FSM state type, the BCD step constant and the 7-segment table.
package calc_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_ABS  = 3'd2,
    S_CONV = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int unsigned TEN       = 32'd10;
  localparam int unsigned TENS_MAX  = 32'd9;
  localparam logic [6:0]  SEG_MINUS = 7'b1111110;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  // Segment order is {a,b,c,d,e,f,g}, active-low.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Tens are counted as a thermometer code so no incrementer is needed.
  function automatic logic [3:0] therm_to_bin(input logic [TENS_MAX-1:0] th);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < int'(TENS_MAX); i++) begin
      d = th[i] ? 4'(i + 1) : d;
    end
    return d;
  endfunction

endpackage

// File: rtl/calc_addsub.sv
// Ripple-carry add/subtract: o_sum = i_a + (i_b ^ {W{i_sub}}) + i_sub.
// o_cout is the final carry (for subtraction: 1 means no borrow, i.e. a >= b).
module calc_addsub #(
  parameter int W = 6
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W-1:0] w_bx;
  logic [W:0]   w_c;

  assign w_bx   = i_b ^ {W{i_sub}};
  assign w_c[0] = i_sub;
  assign o_cout = w_c[W];

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ w_bx[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & w_bx[i]) | (w_c[i] & (i_a[i] ^ w_bx[i]));
  end

endmodule

// File: rtl/calc_sequencer.sv
// Sequential A+B / A-B with signed BCD result, all arithmetic on one shared adder.
// Optional 7-segment outputs HEX0..HEX2 are built only when CALC_SEG_EN is defined.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           CLOCK_50,
  input  logic           rst,
  input  logic           start,
  input  logic           op_sub,
  input  logic [OPW-1:0] a_in,
  input  logic [OPW-1:0] b_in,
  output logic           busy,
  output logic           done,
  output logic           neg,
  output logic [3:0]     tens,
  output logic [3:0]     ones
`ifdef CALC_SEG_EN
  ,
  output logic [0:6]     HEX0,
  output logic [0:6]     HEX1,
  output logic [0:6]     HEX2
`endif
);

  localparam int W = OPW + 2;

  state_t                r_state;
  state_t                w_next;
  logic [OPW-1:0]        r_a;
  logic [OPW-1:0]        r_b;
  logic                  r_sub;
  logic [W-1:0]          r_res;
  logic [W-1:0]          r_mag;
  logic                  r_sign;
  logic [TENS_MAX-1:0]   r_tens_th;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_neg;
  logic [3:0]            r_tens;
  logic [3:0]            r_ones;

  logic [W-1:0]          w_x;
  logic [W-1:0]          w_y;
  logic                  w_sub;
  logic [W-1:0]          w_sum;
  logic                  w_cout;

  calc_addsub #(.W(W)) u_addsub (
    .i_a    (w_x),
    .i_b    (w_y),
    .i_sub  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Next-state logic and shared-adder operand steering.
  always_comb begin
    w_next = r_state;
    w_x    = '0;
    w_y    = '0;
    w_sub  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ADD;
        else       w_next = S_IDLE;
      end
      S_ADD: begin
        w_x    = {2'b00, r_a};
        w_y    = {2'b00, r_b};
        w_sub  = r_sub;
        w_next = S_ABS;
      end
      S_ABS: begin
        w_y    = r_res;
        w_sub  = 1'b1;
        w_next = S_CONV;
      end
      S_CONV: begin
        // Carry out of mag-10 means no borrow, i.e. mag >= 10.
        w_x   = r_mag;
        w_y   = W'(TEN);
        w_sub = 1'b1;
        if (w_cout) w_next = S_CONV;
        else        w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sub     <= 1'b0;
      r_res     <= '0;
      r_mag     <= '0;
      r_sign    <= 1'b0;
      r_tens_th <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_neg     <= 1'b0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_sub <= op_sub;
          end
        end
        S_ADD: r_res <= w_sum;
        S_ABS: begin
          r_sign    <= r_res[W-1];
          r_mag     <= r_res[W-1] ? w_sum : r_res;
          r_tens_th <= '0;
        end
        S_CONV: begin
          if (w_cout) begin
            r_mag     <= w_sum;
            r_tens_th <= {r_tens_th[TENS_MAX-2:0], 1'b1};
          end else begin
            r_tens <= therm_to_bin(r_tens_th);
            r_ones <= r_mag[3:0];
            r_neg  <= r_sign;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign neg  = r_neg;
  assign tens = r_tens;
  assign ones = r_ones;

`ifdef CALC_SEG_EN
  assign HEX0 = seg_digit(r_ones);
  assign HEX1 = seg_digit(r_tens);
  assign HEX2 = r_neg ? SEG_MINUS : SEG_BLANK;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: vector table plus scoreboard queue,
// followed by hand-written sequences for start-during-CONV and mid-CONV reset.
module tb_calc_sequencer;

  localparam int OPW = 4;

  logic           CLOCK_50 = 1'b0;
  logic           rst;
  logic           start;
  logic           op_sub;
  logic [OPW-1:0] a_in;
  logic [OPW-1:0] b_in;
  logic           busy;
  logic           done;
  logic           neg;
  logic [3:0]     tens;
  logic [3:0]     ones;
`ifdef CALC_SEG_EN
  logic [0:6]     HEX0;
  logic [0:6]     HEX1;
  logic [0:6]     HEX2;
`endif

  calc_sequencer #(.OPW(OPW)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .start    (start),
    .op_sub   (op_sub),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .neg      (neg),
    .tens     (tens),
    .ones     (ones)
`ifdef CALC_SEG_EN
    ,
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic op;
    int   a;
    int   b;
    logic en;
    int   et;
    int   eo;
    int   el;
  } vec_t;

  typedef struct {
    logic n;
    int   t;
    int   o;
    int   l;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[10];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic op, input int a, input int b,
                       input logic en, input int et, input int eo, input int el);
    exp_t e;
    @(negedge CLOCK_50);
    start  = 1'b1;
    op_sub = op;
    a_in   = a[OPW-1:0];
    b_in   = b[OPW-1:0];
    e.n = en; e.t = et; e.o = eo; e.l = el;
    sb.push_back(e);
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
  endtask

  // cnt counts rising edges from the one that sampled start (that edge is 1).
  task automatic wait_done(input string tag, input int first);
    int   cnt;
    bit   seen;
    exp_t e;
    cnt  = first;
    seen = 1'b0;
    while (!seen && cnt <= 40) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(posedge CLOCK_50);
        #1;
        cnt++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, cnt);
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: done with no expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " neg"},     {31'd0, neg},  {31'd0, e.n});
      chk({tag, " tens"},    {28'd0, tens}, e.t);
      chk({tag, " ones"},    {28'd0, ones}, e.o);
      chk({tag, " latency"}, cnt,           e.l);
    end
    @(posedge CLOCK_50);
    #1;
    chk({tag, " done_drop"}, {31'd0, done}, 32'd0);
    chk({tag, " busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    vecs[0] = '{1'b0,  9,  5, 1'b0, 1, 4, 5};
    vecs[1] = '{1'b1,  3, 12, 1'b1, 0, 9, 4};
    vecs[2] = '{1'b0, 15, 15, 1'b0, 3, 0, 7};
    vecs[3] = '{1'b0,  0,  0, 1'b0, 0, 0, 4};
    vecs[4] = '{1'b1,  0, 15, 1'b1, 1, 5, 5};
    vecs[5] = '{1'b1, 15,  0, 1'b0, 1, 5, 5};
    vecs[6] = '{1'b1, 10, 10, 1'b0, 0, 0, 4};
    vecs[7] = '{1'b1,  2,  7, 1'b1, 0, 5, 4};
    vecs[8] = '{1'b0,  7,  3, 1'b0, 1, 0, 5};
    vecs[9] = '{1'b1, 12,  1, 1'b0, 1, 1, 5};

    rst    = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    a_in   = '0;
    b_in   = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    rst = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset neg",  {31'd0, neg},  32'd0);
    chk("reset tens", {28'd0, tens}, 32'd0);
    chk("reset ones", {28'd0, ones}, 32'd0);
`ifdef CALC_SEG_EN
    chk("reset HEX2", {25'd0, HEX2}, {25'd0, 7'b1111111});
    chk("reset HEX1", {25'd0, HEX1}, {25'd0, 7'b0000001});
    chk("reset HEX0", {25'd0, HEX0}, {25'd0, 7'b0000001});
`endif

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].en, vecs[i].et, vecs[i].eo, vecs[i].el);
      wait_done($sformatf("vec%0d", i), 1);
`ifdef CALC_SEG_EN
      if (vecs[i].a == 2 && vecs[i].b == 7) begin
        chk("seg 2-7 HEX2", {25'd0, HEX2}, {25'd0, 7'b1111110});
        chk("seg 2-7 HEX1", {25'd0, HEX1}, {25'd0, 7'b0000001});
        chk("seg 2-7 HEX0", {25'd0, HEX0}, {25'd0, 7'b0100100});
      end
`endif
    end

    // Outputs hold in IDLE until the next result.
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("hold tens", {28'd0, tens}, 32'd1);
    chk("hold ones", {28'd0, ones}, 32'd1);

    // Second start during CONV is ignored.
    issue(1'b0, 15, 15, 1'b0, 3, 0, 7);
    repeat (2) begin
      @(posedge CLOCK_50);
      #1;
    end
    @(negedge CLOCK_50);
    start  = 1'b1;
    op_sub = 1'b0;
    a_in   = 4'd1;
    b_in   = 4'd1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    wait_done("conv_start", 4);
    ndone = 0;
    repeat (10) begin
      @(posedge CLOCK_50);
      #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    chk("conv_start extra activity", ndone, 32'd0);
    chk("conv_start tens", {28'd0, tens}, 32'd3);
    chk("conv_start ones", {28'd0, ones}, 32'd0);

    // Reset mid-CONV, with a start coinciding with reset.
    issue(1'b0, 15, 15, 1'b0, 3, 0, 7);
    repeat (3) begin
      @(posedge CLOCK_50);
      #1;
      chk("pre_rst busy", {31'd0, busy}, 32'd1);
    end
    @(negedge CLOCK_50);
    rst    = 1'b1;
    start  = 1'b1;
    op_sub = 1'b1;
    a_in   = 4'd9;
    b_in   = 4'd2;
    @(posedge CLOCK_50);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    sb.delete();
    chk("mid_rst busy", {31'd0, busy}, 32'd0);
    chk("mid_rst done", {31'd0, done}, 32'd0);
    chk("mid_rst neg",  {31'd0, neg},  32'd0);
    chk("mid_rst tens", {28'd0, tens}, 32'd0);
    chk("mid_rst ones", {28'd0, ones}, 32'd0);
    @(posedge CLOCK_50);
    #1;
    chk("mid_rst idle", {31'd0, busy}, 32'd0);

    issue(1'b1, 7, 7, 1'b0, 0, 0, 4);
    wait_done("after_rst 7-7", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
